// File: rtl/led_pkg.sv
// Shared types for the LED frame builder.
// Pixel layout, bus width and the two FSM encodings.
package led_pkg;

    localparam int RGB_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } in_state_e;

    typedef enum logic {
        IDLE = 1'b0,
        ARM  = 1'b1
    } out_state_e;

endpackage

// File: rtl/led_scale.sv
// Per-pixel brightness scaler: ch * (bright + 1) >> 8.
// Used only when LED_FRAME_BRIGHTNESS_EN is defined.
module led_scale
    import led_pkg::*;
(
    input  rgb_t       i_pix,
    input  logic [7:0] i_bright,
    output rgb_t       o_pix
);

    logic [16:0] w_mul;
    logic [16:0] w_r;
    logic [16:0] w_g;
    logic [16:0] w_b;

    assign w_mul = {9'd0, i_bright} + 17'd1;
    assign w_r   = {9'd0, i_pix.r} * w_mul;
    assign w_g   = {9'd0, i_pix.g} * w_mul;
    assign w_b   = {9'd0, i_pix.b} * w_mul;

    // 255 * 256 fits in 16 bits, so [15:8] is the full result
    assign o_pix.r = w_r[15:8];
    assign o_pix.g = w_g[15:8];
    assign o_pix.b = w_b[15:8];

endmodule

// File: rtl/led_frame_builder.sv
// Double-buffered frame builder feeding the WS2801 driver.
// Optional brightness scaling: LED_FRAME_BRIGHTNESS_EN.
module led_frame_builder
    import led_pkg::*;
#(
    parameter int LEDS  = 50,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef LED_FRAME_BRIGHTNESS_EN
    input  logic [7:0]            bright,
`endif
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [RGB_W-1:0]      pix_rgb,
    input  logic                  pix_last,
    input  logic                  drv_done,
    output logic                  drv_start,
    output logic [RGB_W*LEDS-1:0] led_rgb,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic                  short_frame,
    output logic                  overflow
);

    localparam int IDX_W = $clog2(LEDS + 1);
    localparam logic [IDX_W-1:0] LEDS_I = IDX_W'(LEDS);
    localparam logic [IDX_W:0]   LEDS_W = (IDX_W + 1)'(LEDS);

    in_state_e             r_in_st;
    out_state_e            r_out_st;
    logic                  r_ready;
    logic                  r_start;
    logic [IDX_W-1:0]      r_idx;
    logic [RGB_W*LEDS-1:0] r_shadow;
    logic                  r_pend_short;
    logic                  r_pend_ovf;
    logic [RGB_W*LEDS-1:0] r_led;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_short;
    logic                  r_ovf;

    logic                  w_xfer;
    logic                  w_commit;
    logic [IDX_W:0]        w_idx_nx;
    rgb_t                  w_pix;

    assign w_xfer   = pix_valid & r_ready;
    assign w_commit = (r_in_st == HOLD) &&
                      (r_out_st == IDLE) && drv_done;
    assign w_idx_nx = {1'b0, r_idx} + (IDX_W + 1)'(1);

`ifdef LED_FRAME_BRIGHTNESS_EN
    led_scale u_scale (
        .i_pix    (rgb_t'(pix_rgb)),
        .i_bright (bright),
        .o_pix    (w_pix)
    );
`else
    assign w_pix = rgb_t'(pix_rgb);
`endif

    // Input side: collect pixels into the shadow buffer, park in HOLD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_st      <= FILL;
            r_ready      <= 1'b0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_pend_short <= 1'b0;
            r_pend_ovf   <= 1'b0;
        end else begin
            unique case (r_in_st)
                FILL: begin
                    r_ready <= 1'b1;
                    if (w_xfer) begin
                        if (r_idx < LEDS_I) begin
                            for (int k = 0; k < LEDS; k++) begin
                                if (r_idx == IDX_W'(k)) begin
                                    r_shadow[RGB_W*(LEDS-1-k) +: RGB_W]
                                        <= w_pix;
                                end
                            end
                            r_idx <= r_idx + IDX_W'(1);
                        end else begin
                            r_pend_ovf <= 1'b1;
                        end
                        if (pix_last) begin
                            r_in_st      <= HOLD;
                            r_ready      <= 1'b0;
                            r_pend_short <= (w_idx_nx < LEDS_W);
                        end
                    end
                end
                HOLD: begin
                    if (w_commit) begin
                        r_in_st      <= FILL;
                        r_ready      <= 1'b1;
                        r_idx        <= '0;
                        r_pend_short <= 1'b0;
                        r_pend_ovf   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Output side: commit shadow to active buffer, run driver handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_st <= IDLE;
            r_start  <= 1'b0;
            r_led    <= '0;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            unique case (r_out_st)
                IDLE: begin
                    if (w_commit) begin
                        r_out_st <= ARM;
                        r_start  <= 1'b1;
                        r_led    <= r_shadow;
                        r_cnt    <= r_cnt + CNT_W'(1);
                        r_short  <= r_pend_short;
                        r_ovf    <= r_pend_ovf;
                    end
                end
                ARM: begin
                    if (!drv_done) begin
                        r_out_st <= IDLE;
                        r_start  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign pix_ready   = r_ready;
    assign drv_start   = r_start;
    assign led_rgb     = r_led;
    assign frame_cnt   = r_cnt;
    assign short_frame = r_short;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_led_frame_builder.sv
// Scoreboard bench for led_frame_builder (LEDS=3).
// Frame-level reference model plus a randomized driver model.
module tb_led_frame_builder;

    localparam int LEDS = 3;
    localparam int LW   = 24 * LEDS;

    typedef struct {
        logic [LW-1:0] led;
        logic [15:0]   cnt;
        logic          sh;
        logic          ov;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          pix_valid;
    logic          pix_ready;
    logic [23:0]   pix_rgb;
    logic          pix_last;
    wire           drv_done;
    logic          drv_start;
    logic [LW-1:0] led_rgb;
    logic [15:0]   frame_cnt;
    logic          short_frame;
    logic          overflow;
    logic [7:0]    cur_bright;

    logic          drv_mode;
    logic          man_done;
    logic          auto_done;
    logic          done_s;

    int            n_cmp;
    int            n_bad;
    exp_t          expq[$];

    logic [23:0]   mshadow[LEDS];
    int            mn;
    logic [15:0]   mcnt;

    assign drv_done = drv_mode ? auto_done : man_done;

    led_frame_builder #(.LEDS(LEDS), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef LED_FRAME_BRIGHTNESS_EN
        .bright      (cur_bright),
`endif
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_rgb     (pix_rgb),
        .pix_last    (pix_last),
        .drv_done    (drv_done),
        .drv_start   (drv_start),
        .led_rgb     (led_rgb),
        .frame_cnt   (frame_cnt),
        .short_frame (short_frame),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] scale(input logic [23:0] p,
                                          input logic [7:0] b);
`ifdef LED_FRAME_BRIGHTNESS_EN
        int m;
        logic [23:0] o;
        m = int'(b) + 1;
        o[23:16] = 8'((int'(p[23:16]) * m) / 256);
        o[15:8]  = 8'((int'(p[15:8]) * m) / 256);
        o[7:0]   = 8'((int'(p[7:0]) * m) / 256);
        return o;
`else
        if (b == 8'hxx) return 24'h0;
        return p;
`endif
    endfunction

    task automatic mreset();
        for (int k = 0; k < LEDS; k++) mshadow[k] = 24'h0;
        mn   = 0;
        mcnt = 16'h0;
    endtask

    task automatic model_pix(input logic [23:0] rgb, input logic last);
        exp_t e;
        mn++;
        if (mn <= LEDS) mshadow[mn-1] = scale(rgb, cur_bright);
        if (last) begin
            for (int k = 0; k < LEDS; k++)
                e.led[24*(LEDS-k)-1 -: 24] = mshadow[k];
            mcnt  = mcnt + 16'h1;
            e.cnt = mcnt;
            e.sh  = (mn < LEDS);
            e.ov  = (mn > LEDS);
            expq.push_back(e);
            mn = 0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic [23:0] rgb, input logic last);
        int t;
        bit acc;
        pix_valid = 1'b1;
        pix_rgb   = rgb;
        pix_last  = last;
        t   = 0;
        acc = 0;
        while (!acc && t < 2000) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            t++;
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        if (acc) model_pix(rgb, last);
        else chk("pix_accept_timeout", 0, 1);
    endtask

    task automatic send_rand_frame(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0)
                wait_cyc($urandom_range(1, 3));
            send_pix(24'($urandom), (i == n - 1) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (expq.size() > 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (expq.size() > 0) chk("drain_timeout", 1, 0);
        wait_cyc(2);
    endtask

    // Driver model: busy for a random time after each start
    initial begin
        int bcnt;
        bcnt      = 0;
        auto_done = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bcnt > 0) begin
                bcnt--;
                auto_done = 1'b0;
            end else if (drv_start && auto_done &&
                         $urandom_range(0, 1) == 1) begin
                bcnt      = $urandom_range(1, 6);
                auto_done = 1'b0;
            end else if (!drv_start &&
                         $urandom_range(0, 15) == 0) begin
                bcnt      = $urandom_range(1, 3);
                auto_done = 1'b0;
            end else begin
                auto_done = 1'b1;
            end
        end
    end

    always @(posedge clk) done_s <= drv_done;

    // Monitor: every rising drv_start is one committed frame
    initial begin
        logic prev_start;
        logic rst_ok;
        logic [LW-1:0] led_prev;
        exp_t e;
        prev_start = 1'b0;
        rst_ok     = 1'b0;
        led_prev   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_start = 1'b0;
                rst_ok     = 1'b0;
            end else begin
                if (rst_ok && led_rgb !== led_prev)
                    chk("led_change_needs_done", done_s, 1);
                rst_ok = 1'b1;
                if (drv_start && !prev_start) begin
                    if (expq.size() == 0) begin
                        chk("commit_unexpected", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("led_rgb", led_rgb, e.led);
                        chk("frame_cnt", frame_cnt, e.cnt);
                        chk("short_frame", short_frame, e.sh);
                        chk("overflow", overflow, e.ov);
                    end
                end
                prev_start = drv_start;
            end
            led_prev = led_rgb;
        end
    end

    initial begin
        logic [LW-1:0] led_a;
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b0;
        pix_valid  = 1'b0;
        pix_rgb    = 24'h0;
        pix_last   = 1'b0;
        drv_mode   = 1'b0;
        man_done   = 1'b1;
        cur_bright = 8'd255;
        mreset();
        wait_cyc(3);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_drv_start", drv_start, 0);
        chk("rst_led_rgb", led_rgb, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_short", short_frame, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b1;
        wait_cyc(2);

        send_pix(24'hFF0000, 1'b0);
        send_pix(24'h00FF00, 1'b0);
        send_pix(24'h0000FF, 1'b1);
        @(negedge clk);
        chk("lat1_pix_ready", pix_ready, 0);
        chk("lat1_drv_start", drv_start, 0);
        @(negedge clk);
        chk("lat2_drv_start", drv_start, 1);
        chk("lat2_pix_ready", pix_ready, 1);
        chk("lat2_frame_cnt", frame_cnt, 1);
        led_a = 72'hFF000000FF000000FF;
        chk("frameA_led", led_rgb, led_a);
        @(posedge clk);
        #1;

        send_pix(24'($urandom), 1'b0);
        send_pix(24'($urandom), 1'b0);
        send_pix(24'h0000FF, 1'b1);
        wait_cyc(3);
        @(negedge clk);
        chk("hold_drv_start", drv_start, 1);
        chk("hold_pix_ready", pix_ready, 0);
        chk("hold_led", led_rgb, led_a);
        @(posedge clk);
        #1;
        man_done = 1'b0;
        wait_cyc(2);
        @(negedge clk);
        chk("busy_drv_start", drv_start, 0);
        chk("busy_led", led_rgb, led_a);
        chk("busy_frame_cnt", frame_cnt, 1);
        @(posedge clk);
        #1;
        man_done = 1'b1;
        wait_drain();
        chk("frameB_cnt", frame_cnt, 2);

        drv_mode = 1'b1;
        send_pix(24'h111111, 1'b0);
        send_pix(24'h222222, 1'b1);
        send_rand_frame(5);
        send_rand_frame(3);
        wait_drain();

`ifdef LED_FRAME_BRIGHTNESS_EN
        cur_bright = 8'd127;
        send_pix(24'hFF8002, 1'b0);
        send_rand_frame(2);
        wait_drain();
        chk("bright127", led_rgb[71:48], 24'h7F4001);
        cur_bright = 8'd255;
        send_pix(24'hFF8002, 1'b0);
        send_rand_frame(2);
        wait_drain();
        chk("bright255", led_rgb[71:48], 24'hFF8002);
`endif

        for (int f = 0; f < 60; f++) begin
`ifdef LED_FRAME_BRIGHTNESS_EN
            cur_bright = 8'($urandom);
`endif
            send_rand_frame($urandom_range(1, 5));
        end
        wait_drain();
        cur_bright = 8'd255;

        drv_mode = 1'b0;
        man_done = 1'b1;
        wait_cyc(2);
        send_pix(24'($urandom), 1'b0);
        rst = 1'b0;
        #1;
        chk("rstmid_drv_start", drv_start, 0);
        chk("rstmid_led", led_rgb, 0);
        chk("rstmid_pix_ready", pix_ready, 0);
        chk("rstmid_frame_cnt", frame_cnt, 0);
        expq.delete();
        mreset();
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(1);
        send_rand_frame(3);
        wait_cyc(2);
        @(negedge clk);
        chk("arm_drv_start", drv_start, 1);
        rst = 1'b0;
        #1;
        chk("rstarm_drv_start", drv_start, 0);
        chk("rstarm_led", led_rgb, 0);
        expq.delete();
        mreset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_cyc(1);
        send_rand_frame(3);
        wait_drain();
        chk("fresh_frame_cnt", frame_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_frame_builder.md
Name: led_frame_builder

Overview:
- Upstream neighbour of the WS2801 LED driver; sits between the visualizer and the driver.
- Collects a per-LED pixel stream from the visualizer into a shadow buffer.
- Commits a complete frame to a stable active buffer that drives led_rgb, and runs the start/done handshake with the driver.
- Double buffering lets the visualizer fill frame N+1 while frame N is being shifted out.

Parameters:
- LEDS, 50, number of LEDs in the strip; the buffer is 24*LEDS bits wide.
- CNT_W, 16, width of the frames-sent counter.

Ports:
- clk  in  1  system clock; same clock as the driver.
- rst  in  1  asynchronous, active-low reset.
- pix_valid  in  1  visualizer offers a pixel.
- pix_ready  out  1  block accepts a pixel; a transfer occurs when valid & ready.
- pix_rgb  in  24  pixel, red[23:16] green[15:8] blue[7:0].
- pix_last  in  1  marks the final pixel of a frame.
- drv_done  in  1  driver's done output; 1 means the driver is idle and waiting.
- drv_start  out  1  driver's start input.
- led_rgb  out  24*LEDS  active buffer; LED0 occupies [24*LEDS-1 -: 24], LED k occupies [24*(LEDS-k)-1 -: 24].
- frame_cnt  out  CNT_W  number of frames committed; wraps.
- short_frame  out  1  last committed frame had fewer than LEDS pixels.
- overflow  out  1  last committed frame had more than LEDS pixels.

Behaviour:
- Reset (rst low, asynchronous): all outputs are 0. This covers pix_ready, drv_start, led_rgb (strip black), frame_cnt, short_frame, overflow, the shadow buffer and the write index. Input FSM goes to FILL; output FSM goes to IDLE.
- Reset mid-frame or mid-handshake discards partial data. drv_start drops immediately (asynchronously).
- Input FSM {FILL, HOLD}:
  - FILL: pix_ready=1.
  - Each accepted pixel with index < LEDS is written to shadow slot idx, then idx increments.
  - Accepted pixels with idx >= LEDS are dropped, idx saturates at LEDS, and a pending overflow flag is set.
  - An accepted pixel with pix_last=1 moves the FSM to HOLD. pending_short = (idx+1 < LEDS), evaluated on that beat.
  - HOLD: pix_ready=0.
- Output FSM {IDLE, ARM}.
- Commit: fires in the cycle where input=HOLD, output=IDLE and drv_done=1. At that clock edge:
  - led_rgb <= shadow;
  - frame_cnt += 1;
  - short_frame/overflow <= pending flags;
  - idx and pending flags clear;
  - input -> FILL; output -> ARM.
- Shadow slots not written in a short frame keep their previous values. They are not zeroed.
- ARM: drv_start=1, held until drv_done is sampled 0, then output -> IDLE and drv_start=0 the next cycle. led_rgb never changes while drv_done=0.
- Latency: last pixel accepted at edge N gives HOLD in cycle N+1. With drv_done=1, the commit happens at edge N+1, and drv_start=1 plus pix_ready=1 appear in cycle N+2.
- Back-to-back frames: a frame reaching HOLD while output=ARM, or while drv_done=0, waits in HOLD and back-pressures the visualizer. There are no drops.
- drv_done=0 in IDLE (driver busy for another reason) blocks the commit.
- Frame with pix_last on the first pixel: a 1-pixel frame, short_frame=1 when LEDS>1.

Optional Feature:
- Macro: LED_FRAME_BRIGHTNESS_EN.
- Defined:
  - Adds input port bright[7:0].
  - Each channel is scaled on write as ch_out = (ch * (bright+1)) >> 8, truncated to 8 bits.
  - bright=255 gives identity; bright=0 gives ch>>8 = 0.
  - bright is sampled on the accepting beat, with no added latency.
- Undefined: no bright port; pixels are stored unmodified.

Decomposition:
- Package led_pkg holds:
  - typedef rgb_t (packed struct r, g, b of 8 bits each);
  - localparam RGB_W=24;
  - enums in_state_e {FILL, HOLD} and out_state_e {IDLE, ARM}.
- One sub-module, led_scale, holds the per-pixel brightness multiply. It is instantiated only under LED_FRAME_BRIGHTNESS_EN.

Test Plan:
- LEDS=3, drv_done=1; send 0xFF0000, 0x00FF00, 0x0000FF (last on the third) -> led_rgb=0xFF000000FF000000FF, frame_cnt=1, drv_start high two cycles after the last beat and held until drv_done=0.
- While in ARM, send a second 3-pixel frame -> it reaches HOLD, pix_ready=0, and led_rgb stays unchanged until drv_done goes 0 then 1. Commit follows, frame_cnt=2.
- Send a 2-pixel frame 0x111111, 0x222222 with last -> short_frame=1; LED2 slot keeps 0x0000FF from the prior frame.
- Send 5 pixels, last on the fifth -> overflow=1; only the first 3 are stored; the next normal frame clears overflow.
- Assert rst low mid-frame (1 pixel in) and during ARM -> drv_start=0 and led_rgb=0 immediately. A fresh 3-pixel frame afterwards commits with frame_cnt=1.
- With LED_FRAME_BRIGHTNESS_EN: bright=127, pixel 0xFF8002 -> stored 0x7F4001; bright=255 -> 0xFF8002 unchanged.
